decoder_3x8_seq: RTL and testbench
==================================

// Module: decoder_3x8_seq
// PURPOSE
//  Sequenced 3-to-8 decoder: the inverse of the 8x3 priority encoder.
//  Accepts {v,a[2:0]} code words over a valid/ready handshake and buffers them in a small FIFO.
//  Drives each decoded one-hot word on d[7:0] for HOLD cycles, then GAP cycles of zero.
//  Sits downstream of the encoder to regenerate timed strobe lines from encoded events.
// PARAMETERS
//  DEPTH  2  FIFO entries (>=1)
//  HOLD   4  cycles each decoded word is driven on d (>=1)
//  GAP    1  all-zero cycles after each word (>=0)
// PORTS
//  clk       in   1  single clock, rising edge
//  rst       in   1  asynchronous, active-high reset
//  in_valid  in   1  code word present on a/v
//  in_ready  out  1  FIFO can accept; high when entry count < DEPTH
//  a         in   3  encoded index
//  v         in   1  encoder valid; v=0 means "no line active"
//  d         out  8  decoded one-hot (registered)
//  d_valid   out  1  high while d carries a decoded word (HOLD phase)
//  busy      out  1  state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (async, immediate, also mid-operation): d=0, d_valid=0, state=IDLE, FIFO empty.
//   Hence in_ready=1 and busy=0.
//  Push: in_valid&&in_ready at a rising edge writes {v,a}; in_ready uses the registered count only.
//   No push occurs at count==DEPTH, even when a pop happens in the same cycle.
//  Decode: d_new = v ? (8'h01 << a) : 8'h00; the v=0 word still runs a full HOLD with d_valid=1.
//  FSM: IDLE, DRIVE, GAP; down-counter cnt sized $clog2(max(HOLD,GAP)+1).
//  IDLE: if FIFO non-empty -> pop, d<=d_new, d_valid<=1, cnt<=HOLD-1, go DRIVE.
//  DRIVE: cnt!=0 -> cnt--.
//   cnt==0 && GAP>0 -> d<=0, d_valid<=0, cnt<=GAP-1, go GAP.
//   cnt==0 && GAP==0 && FIFO non-empty -> pop and load the next word directly (stay DRIVE).
//   cnt==0 && GAP==0 && FIFO empty -> d<=0, d_valid<=0, go IDLE.
//  GAP: cnt!=0 -> cnt--. cnt==0 -> pop/load into DRIVE if FIFO non-empty, else go IDLE.
//  Latency: a word pushed into an empty FIFO at edge N appears on d after edge N+1.
//  Simultaneous push and pop on a non-full FIFO: both occur and the count is unchanged.
//   On an empty FIFO, the word pushed at edge N is popped no earlier than edge N+1.
//  FIFO pointers wrap modulo DEPTH. Words leave in strict arrival order and none are dropped.
// CONFIGURATION
//  DECODER_ACCUM_EN defined: adds ports clr_seen (in, 1) and seen (out, 8, reset 0).
//   Every load does seen <= seen | d_new.
//   clr_seen does seen <= 0; if a load occurs in the same cycle, seen <= d_new.
//  DECODER_ACCUM_EN undefined: the clr_seen and seen ports and their logic are absent.
//   All other behaviour is identical.
// STRUCTURE
//  Shared package decoder_pkg holds:
//   - state encodings ST_IDLE/ST_DRIVE/ST_GAP
//   - CODE_W=4 constant
//   - onehot8(v,a) function, also used by the bench model.
//  Sub-module dec_fifo (DEPTH, WIDTH=4): push/pop/full/empty/count, async reset.
//  The top level holds the FSM, counter, output registers and accumulator.
// TESTING
//  1 HOLD=4 GAP=1: push v=1 a=3 -> d=8'h08, d_valid=1 for 4 cycles; then 1 cycle d=0; IDLE, busy=0.
//  2 Push v=0 a=5 -> d=8'h00 with d_valid=1 for 4 cycles; no one-hot bit ever set.
//  3 DEPTH=2: push a=0,7,5,2 (v=1) back to back.
//    -> in_ready drops while count=2.
//    -> d sequence 01,80,20,04, each for 4 cycles with 1 zero gap between; no loss or reordering.
//  4 GAP=0: push a=1 then a=6 -> 8'h02 for 4 cycles, then 8'h40 on the very next cycle.
//    d_valid stays high throughout.
//  5 Assert rst mid-DRIVE, asynchronously between edges.
//    -> d=0, d_valid=0, busy=0 immediately; FIFO contents discarded.
//  6 DECODER_ACCUM_EN: codes 1,6 -> seen=8'h42.
//    clr_seen in the same cycle as the load of a=0 -> seen=8'h01.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 decoder.
// Optional accumulator feature is enabled by defining DECODER_ACCUM_EN.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int CODE_W = 4;

    function automatic logic [7:0] onehot8(input logic v, input logic [2:0] a);
        return v ? (8'h01 << a) : 8'h00;
    endfunction

endpackage

// File: rtl/dec_fifo.sv
// Small circular FIFO holding {v,a} code words; pointers wrap modulo DEPTH.
module dec_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push) begin
            mem_d[wr_q] = din;
            wr_d        = next_ptr(wr_q);
        end
        if (do_pop) begin
            rd_d = next_ptr(rd_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/decoder_3x8_seq.sv
// Sequenced 3-to-8 decoder: FIFO-buffered code words driven as timed one-hot strobes.
// Defining DECODER_ACCUM_EN adds the clr_seen/seen accumulator ports.
module decoder_3x8_seq
    import decoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int HOLD  = 4,
    parameter int GAP   = 1
) (
    input  logic       clk,
    input  logic       rst,
`ifdef DECODER_ACCUM_EN
    input  logic       clr_seen,
    output logic [7:0] seen,
`endif
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] a,
    input  logic       v,
    output logic [7:0] d,
    output logic       d_valid,
    output logic       busy
);

    localparam int MAX_HG = (HOLD > GAP) ? HOLD : GAP;
    localparam int CNT_W  = $clog2(MAX_HG + 1);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [7:0]          d_q, d_d;
    logic                d_valid_q, d_valid_d;
    logic                load;
    logic                push;
    logic [CODE_W-1:0]   fifo_dout;
    logic                fifo_full, fifo_empty;
    logic [FCNT_W-1:0]   fifo_count;
    logic [7:0]          d_new;

    assign push     = in_valid && in_ready;
    assign in_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || (fifo_count != '0);
    assign d        = d_q;
    assign d_valid  = d_valid_q;
    assign d_new    = onehot8(fifo_dout[3], fifo_dout[2:0]);

    dec_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CODE_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (load),
        .din   ({v, a}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        d_valid_d = d_valid_q;
        load      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) load = 1'b1;
            end
            ST_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (GAP > 0) begin
                    d_d       = '0;
                    d_valid_d = 1'b0;
                    cnt_d     = GAP_LD;
                    state_d   = ST_GAP;
                end else if (!fifo_empty) begin
                    load = 1'b1;
                end else begin
                    d_d       = '0;
                    d_valid_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else if (!fifo_empty) load = 1'b1;
                else state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Every load path (from IDLE, GAP, or back-to-back DRIVE) shares this update.
        if (load) begin
            d_d       = d_new;
            d_valid_d = 1'b1;
            cnt_d     = HOLD_LD;
            state_d   = ST_DRIVE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            d_q       <= '0;
            d_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            d_q       <= d_d;
            d_valid_q <= d_valid_d;
        end
    end

`ifdef DECODER_ACCUM_EN
    logic [7:0] seen_q, seen_d;

    assign seen = seen_q;

    always_comb begin
        seen_d = seen_q;
        if (clr_seen) seen_d = '0;
        if (load) seen_d = seen_d | d_new;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) seen_q <= '0;
        else     seen_q <= seen_d;
    end
`endif

endmodule

// File: tb/tb_decoder_3x8_seq.sv
// Directed self-checking bench for decoder_3x8_seq (GAP=1 and GAP=0 instances).
module tb_decoder_3x8_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid_a, v_a, in_ready_a, d_valid_a, busy_a;
    logic [2:0] a_a;
    logic [7:0] d_a;
    logic       in_valid_b, v_b, in_ready_b, d_valid_b, busy_b;
    logic [2:0] a_b;
    logic [7:0] d_b;
`ifdef DECODER_ACCUM_EN
    logic       clr_seen_a, clr_seen_b;
    logic [7:0] seen_a, seen_b;
`endif

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    decoder_3x8_seq #(.DEPTH(2), .HOLD(4), .GAP(1)) dut_a (
        .clk      (clk),
        .rst      (rst),
`ifdef DECODER_ACCUM_EN
        .clr_seen (clr_seen_a),
        .seen     (seen_a),
`endif
        .in_valid (in_valid_a),
        .in_ready (in_ready_a),
        .a        (a_a),
        .v        (v_a),
        .d        (d_a),
        .d_valid  (d_valid_a),
        .busy     (busy_a)
    );

    decoder_3x8_seq #(.DEPTH(2), .HOLD(4), .GAP(0)) dut_b (
        .clk      (clk),
        .rst      (rst),
`ifdef DECODER_ACCUM_EN
        .clr_seen (clr_seen_b),
        .seen     (seen_b),
`endif
        .in_valid (in_valid_b),
        .in_ready (in_ready_b),
        .a        (a_b),
        .v        (v_b),
        .d        (d_b),
        .d_valid  (d_valid_b),
        .busy     (busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Push one word on instance A and follow it through HOLD=4 then GAP=1 back to idle.
    task automatic run_word(input logic vv, input logic [2:0] aa, input logic [7:0] exp);
        in_valid_a = 1'b1; v_a = vv; a_a = aa;
        tick();
        in_valid_a = 1'b0;
        chk("latency_d", {24'd0, d_a}, 32'h00);
        chk("latency_busy", {31'd0, busy_a}, 32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_d", {24'd0, d_a}, {24'd0, exp});
            chk("hold_dv", {31'd0, d_valid_a}, 32'd1);
            tick();
        end
        chk("gap_d", {24'd0, d_a}, 32'h00);
        chk("gap_dv", {31'd0, d_valid_a}, 32'd0);
        chk("gap_busy", {31'd0, busy_a}, 32'd1);
        tick();
        chk("idle_busy", {31'd0, busy_a}, 32'd0);
        chk("idle_dv", {31'd0, d_valid_a}, 32'd0);
    endtask

    logic [2:0] seq_a [4];
    logic [7:0] seq_d [4];
    int idx, off, w;

    initial begin
        rst = 1'b1;
        in_valid_a = 1'b0; v_a = 1'b0; a_a = '0;
        in_valid_b = 1'b0; v_b = 1'b0; a_b = '0;
`ifdef DECODER_ACCUM_EN
        clr_seen_a = 1'b0; clr_seen_b = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("rst_d", {24'd0, d_a}, 32'h00);
        chk("rst_dv", {31'd0, d_valid_a}, 32'd0);
        chk("rst_ready", {31'd0, in_ready_a}, 32'd1);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        tick();

        // Single one-hot word, then the v=0 word.
        run_word(1'b1, 3'd3, 8'h08);
        tick();
        run_word(1'b0, 3'd5, 8'h00);
        tick();

        // Back-to-back pushes against DEPTH=2; k counts negedges from the first drive.
        seq_a[0] = 3'd0; seq_a[1] = 3'd7; seq_a[2] = 3'd5; seq_a[3] = 3'd2;
        seq_d[0] = 8'h01; seq_d[1] = 8'h80; seq_d[2] = 8'h20; seq_d[3] = 8'h04;
        idx = 0;
        for (int k = 0; k <= 22; k++) begin
            if (k >= 2 && k <= 21) begin
                off = (k - 2) % 5;
                w   = (k - 2) / 5;
                if (off < 4) begin
                    chk("burst_d", {24'd0, d_a}, {24'd0, seq_d[w]});
                    chk("burst_dv", {31'd0, d_valid_a}, 32'd1);
                end else begin
                    chk("burst_gap_d", {24'd0, d_a}, 32'h00);
                    chk("burst_gap_dv", {31'd0, d_valid_a}, 32'd0);
                end
            end
            if (k == 3) chk("full_ready", {31'd0, in_ready_a}, 32'd0);
            if (k == 7) chk("refill_ready", {31'd0, in_ready_a}, 32'd1);
            if (k == 22) chk("burst_busy", {31'd0, busy_a}, 32'd0);
            if (idx < 4) begin
                in_valid_a = 1'b1; v_a = 1'b1; a_a = seq_a[idx];
                if (in_ready_a) idx++;
            end else begin
                in_valid_a = 1'b0;
            end
            tick();
        end
        chk("burst_all_pushed", idx, 32'd4);

        // GAP=0: second word follows the first with no idle cycle.
        in_valid_b = 1'b1; v_b = 1'b1; a_b = 3'd1;
        tick();
        a_b = 3'd6;
        tick();
        in_valid_b = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("nogap_d", {24'd0, d_b}, (k < 4) ? 32'h02 : 32'h40);
            chk("nogap_dv", {31'd0, d_valid_b}, 32'd1);
            tick();
        end
        chk("nogap_end_d", {24'd0, d_b}, 32'h00);
        chk("nogap_end_dv", {31'd0, d_valid_b}, 32'd0);
        chk("nogap_end_busy", {31'd0, busy_b}, 32'd0);
        tick();

        // Asynchronous reset mid-DRIVE with a word still queued.
        in_valid_a = 1'b1; v_a = 1'b1; a_a = 3'd4;
        tick();
        a_a = 3'd2;
        tick();
        in_valid_a = 1'b0;
        chk("pre_rst_d", {24'd0, d_a}, 32'h10);
        chk("pre_rst_busy", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_d", {24'd0, d_a}, 32'h00);
        chk("async_rst_dv", {31'd0, d_valid_a}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("async_rst_ready", {31'd0, in_ready_a}, 32'd1);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("post_rst_d", {24'd0, d_a}, 32'h00);
            chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
        end

`ifdef DECODER_ACCUM_EN
        in_valid_a = 1'b1; v_a = 1'b1; a_a = 3'd1;
        tick();
        a_a = 3'd6;
        tick();
        in_valid_a = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        chk("seen_accum", {24'd0, seen_a}, 32'h42);
        in_valid_a = 1'b1; a_a = 3'd0;
        tick();
        in_valid_a = 1'b0;
        clr_seen_a = 1'b1;
        tick();
        clr_seen_a = 1'b0;
        chk("seen_clr_load", {24'd0, seen_a}, 32'h01);
        chk("seen_clr_d", {24'd0, d_a}, 32'h01);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
